// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel time-of-day alarm with ring, snooze and dismiss
module alarm_bank #(
    parameter int NUM_ALARMS  = 4,
    parameter int SEC_W       = 17,
    parameter int LEN_W       = 8,
    parameter int MUS_W       = 2,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [SEC_W-1:0]      cur_seconds,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic                  wr_arm,
    input  logic [SEC_W-1:0]      wr_time,
    input  logic [LEN_W-1:0]      wr_len,
    input  logic [MUS_W-1:0]      wr_music,
    output logic                  wr_err,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [NUM_ALARMS-1:0] ring_mask,
    output logic [NUM_ALARMS-1:0] snooze_mask,
    output logic                  ring_any,
    output logic [IW-1:0]         ring_idx,
    output logic [MUS_W-1:0]      ring_music,
    output logic [NUM_ALARMS-1:0] armed_mask
);
    localparam int SW = (SNOOZE_SECS > 0) ? $clog2(SNOOZE_SECS + 1) : 1;
    localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam int unsigned DAY = 86400;

    typedef enum logic [1:0] {IDLE, RING, SNZ} st_t;

    st_t              st_q    [NUM_ALARMS];
    st_t              st_d    [NUM_ALARMS];
    logic             arm_q   [NUM_ALARMS];
    logic             arm_d   [NUM_ALARMS];
    logic [SEC_W-1:0] tm_q    [NUM_ALARMS];
    logic [SEC_W-1:0] tm_d    [NUM_ALARMS];
    logic [LEN_W-1:0] len_q   [NUM_ALARMS];
    logic [LEN_W-1:0] len_d   [NUM_ALARMS];
    logic [MUS_W-1:0] mus_q   [NUM_ALARMS];
    logic [MUS_W-1:0] mus_d   [NUM_ALARMS];
    logic [LEN_W-1:0] rc_q    [NUM_ALARMS];
    logic [LEN_W-1:0] rc_d    [NUM_ALARMS];
    logic [SW-1:0]    sc_q    [NUM_ALARMS];
    logic [SW-1:0]    sc_d    [NUM_ALARMS];
    logic [CW-1:0]    cnt_q   [NUM_ALARMS];
    logic [CW-1:0]    cnt_d   [NUM_ALARMS];
    // set when a channel fires, held until the time of day moves off its trigger second
    logic             fired_q [NUM_ALARMS];
    logic             fired_d [NUM_ALARMS];

    logic [NUM_ALARMS-1:0] ring_mask_q, ring_mask_d;
    logic [NUM_ALARMS-1:0] snooze_mask_q, snooze_mask_d;
    logic [NUM_ALARMS-1:0] armed_mask_q, armed_mask_d;
    logic                  ring_any_q, ring_any_d;
    logic [IW-1:0]         ring_idx_q, ring_idx_d;
    logic [MUS_W-1:0]      ring_music_q, ring_music_d;
    logic                  wr_err_q, wr_err_d;
    logic                  wr_ok, day_ok;

    // per-channel next state: write beats dismiss beats snooze beats tick
    always_comb begin
        wr_ok    = wr_en && (32'(wr_time) < DAY);
        day_ok   = 32'(cur_seconds) < DAY;
        wr_err_d = wr_en && !wr_ok;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            st_d[i]    = st_q[i];
            arm_d[i]   = arm_q[i];
            tm_d[i]    = tm_q[i];
            len_d[i]   = len_q[i];
            mus_d[i]   = mus_q[i];
            rc_d[i]    = rc_q[i];
            sc_d[i]    = sc_q[i];
            cnt_d[i]   = cnt_q[i];
            fired_d[i] = fired_q[i];
            if (sec_tick && cur_seconds != tm_q[i])
                fired_d[i] = 1'b0;
            if (st_q[i] == IDLE) begin
                if (sec_tick && day_ok && arm_q[i] && cur_seconds == tm_q[i] && !fired_q[i]) begin
                    st_d[i]    = RING;
                    rc_d[i]    = (len_q[i] == '0) ? LEN_W'(1) : len_q[i];
                    cnt_d[i]   = '0;
                    fired_d[i] = 1'b1;
                end
            end else if (dismiss) begin
                st_d[i] = IDLE;
            end else if (st_q[i] == RING) begin
                if (snooze) begin
                    if (cnt_q[i] < CW'(MAX_SNOOZE)) begin
                        st_d[i]  = SNZ;
                        sc_d[i]  = SW'(SNOOZE_SECS);
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end else begin
                        st_d[i] = IDLE;
                    end
                end else if (sec_tick) begin
                    rc_d[i] = rc_q[i] - LEN_W'(1);
                    st_d[i] = (rc_q[i] <= LEN_W'(1)) ? IDLE : RING;
                end
            end else if (sec_tick) begin
                sc_d[i] = sc_q[i] - SW'(1);
                if (sc_q[i] <= SW'(1)) begin
                    st_d[i] = RING;
                    rc_d[i] = (len_q[i] == '0) ? LEN_W'(1) : len_q[i];
                end
            end
            if (wr_ok && wr_idx == IW'(i)) begin
                arm_d[i]   = wr_arm;
                tm_d[i]    = wr_time;
                len_d[i]   = wr_len;
                mus_d[i]   = wr_music;
                st_d[i]    = IDLE;
                rc_d[i]    = '0;
                sc_d[i]    = '0;
                cnt_d[i]   = '0;
                fired_d[i] = 1'b0;
            end
            ring_mask_d[i]   = st_d[i] == RING;
            snooze_mask_d[i] = st_d[i] == SNZ;
            armed_mask_d[i]  = arm_d[i];
        end
        ring_any_d   = |ring_mask_d;
        ring_idx_d   = '0;
        ring_music_d = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_mask_d[i]) begin
                ring_idx_d   = IW'(i);
                ring_music_d = mus_d[i];
            end
        end
    end

    // channel state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st_q[i]    <= IDLE;
                arm_q[i]   <= 1'b0;
                tm_q[i]    <= '0;
                len_q[i]   <= '0;
                mus_q[i]   <= '0;
                rc_q[i]    <= '0;
                sc_q[i]    <= '0;
                cnt_q[i]   <= '0;
                fired_q[i] <= 1'b0;
            end
            ring_mask_q   <= '0;
            snooze_mask_q <= '0;
            armed_mask_q  <= '0;
            ring_any_q    <= 1'b0;
            ring_idx_q    <= '0;
            ring_music_q  <= '0;
            wr_err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st_q[i]    <= st_d[i];
                arm_q[i]   <= arm_d[i];
                tm_q[i]    <= tm_d[i];
                len_q[i]   <= len_d[i];
                mus_q[i]   <= mus_d[i];
                rc_q[i]    <= rc_d[i];
                sc_q[i]    <= sc_d[i];
                cnt_q[i]   <= cnt_d[i];
                fired_q[i] <= fired_d[i];
            end
            ring_mask_q   <= ring_mask_d;
            snooze_mask_q <= snooze_mask_d;
            armed_mask_q  <= armed_mask_d;
            ring_any_q    <= ring_any_d;
            ring_idx_q    <= ring_idx_d;
            ring_music_q  <= ring_music_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign ring_mask   = ring_mask_q;
    assign snooze_mask = snooze_mask_q;
    assign armed_mask  = armed_mask_q;
    assign ring_any    = ring_any_q;
    assign ring_idx    = ring_idx_q;
    assign ring_music  = ring_music_q;
    assign wr_err      = wr_err_q;
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed vector table plus hand sequences for alarm_bank
module tb_alarm_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sec_tick = 1'b0;
    logic [16:0] cur_seconds = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic        wr_arm = 1'b0;
    logic [16:0] wr_time = '0;
    logic [7:0]  wr_len = '0;
    logic [1:0]  wr_music = '0;
    logic        wr_err;
    logic        dismiss = 1'b0;
    logic        snooze = 1'b0;
    logic [3:0]  ring_mask, snooze_mask, armed_mask;
    logic        ring_any;
    logic [1:0]  ring_idx, ring_music;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int we, wi, wa, wt, wl, wm, tk, cs, ds, sn;
        int rm, sm, ri, rmu, am, er;
    } vec_t;
    vec_t tbl[$];

    alarm_bank dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .cur_seconds(cur_seconds),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_arm(wr_arm), .wr_time(wr_time),
        .wr_len(wr_len), .wr_music(wr_music), .wr_err(wr_err),
        .dismiss(dismiss), .snooze(snooze), .ring_mask(ring_mask),
        .snooze_mask(snooze_mask), .ring_any(ring_any), .ring_idx(ring_idx),
        .ring_music(ring_music), .armed_mask(armed_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int rm, input int sm, input int ri,
                           input int rmu, input int am, input int er);
        chk({nm, " ring_mask"}, int'(ring_mask), rm);
        chk({nm, " snooze_mask"}, int'(snooze_mask), sm);
        chk({nm, " ring_any"}, int'(ring_any), int'(rm != 0));
        chk({nm, " ring_idx"}, int'(ring_idx), ri);
        chk({nm, " ring_music"}, int'(ring_music), rmu);
        chk({nm, " armed_mask"}, int'(armed_mask), am);
        chk({nm, " wr_err"}, int'(wr_err), er);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        sec_tick = 1'b0;
        dismiss = 1'b0;
        snooze = 1'b0;
    endtask

    task automatic wr(input int idx, input int arm, input int t, input int len, input int mus);
        wr_en = 1'b1;
        wr_idx = 2'(idx);
        wr_arm = 1'(arm);
        wr_time = 17'(t);
        wr_len = 8'(len);
        wr_music = 2'(mus);
        cyc();
    endtask

    task automatic tick(input int s);
        sec_tick = 1'b1;
        cur_seconds = 17'(s);
        cyc();
    endtask

    initial begin
        //            we wi wa wt     wl wm tk cs   ds sn   rm    sm ri rmu am    er
        tbl.push_back('{1, 1, 1, 100,  3, 2, 0, 0,   0, 0, 4'h0, 0, 0, 0, 4'h2, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 99,  0, 0, 4'h0, 0, 0, 0, 4'h2, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 100, 0, 0, 4'h2, 0, 1, 2, 4'h2, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 101, 0, 0, 4'h2, 0, 1, 2, 4'h2, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 0, 101, 0, 0, 4'h2, 0, 1, 2, 4'h2, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 102, 0, 0, 4'h2, 0, 1, 2, 4'h2, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 103, 0, 0, 4'h0, 0, 0, 0, 4'h2, 0});
        tbl.push_back('{1, 1, 0, 86400,9, 1, 0, 103, 0, 0, 4'h0, 0, 0, 0, 4'h2, 1});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 0, 103, 0, 0, 4'h0, 0, 0, 0, 4'h2, 0});
        tbl.push_back('{1, 0, 1, 50,   0, 1, 0, 103, 0, 0, 4'h0, 0, 0, 0, 4'h3, 0});
        tbl.push_back('{1, 2, 1, 50,   5, 3, 0, 103, 0, 0, 4'h0, 0, 0, 0, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 50,  0, 0, 4'h5, 0, 0, 1, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 50,  0, 0, 4'h4, 0, 2, 3, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 0, 50,  1, 0, 4'h0, 0, 0, 0, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 50,  0, 0, 4'h0, 0, 0, 0, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 51,  0, 0, 4'h0, 0, 0, 0, 4'h7, 0});
        tbl.push_back('{1, 1, 0, 52,   1, 0, 0, 51,  0, 0, 4'h0, 0, 0, 0, 4'h5, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 52,  0, 0, 4'h0, 0, 0, 0, 4'h5, 0});
        tbl.push_back('{1, 1, 1, 53,   1, 0, 0, 52,  0, 0, 4'h0, 0, 0, 0, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 53,  0, 0, 4'h2, 0, 1, 0, 4'h7, 0});
        tbl.push_back('{0, 0, 0, 0,    0, 0, 1, 54,  0, 0, 4'h0, 0, 0, 0, 4'h7, 0});

        repeat (2) cyc();
        rst = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            wr_en = 1'(tbl[k].we);
            wr_idx = 2'(tbl[k].wi);
            wr_arm = 1'(tbl[k].wa);
            wr_time = 17'(tbl[k].wt);
            wr_len = 8'(tbl[k].wl);
            wr_music = 2'(tbl[k].wm);
            sec_tick = 1'(tbl[k].tk);
            cur_seconds = 17'(tbl[k].cs);
            dismiss = 1'(tbl[k].ds);
            snooze = 1'(tbl[k].sn);
            cyc();
            chk_all($sformatf("row%0d", k), tbl[k].rm, tbl[k].sm, tbl[k].ri,
                    tbl[k].rmu, tbl[k].am, tbl[k].er);
        end

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr(0, 1, 200, 2, 1);
        tick(200);
        chk_all("snz trig", 1, 0, 0, 1, 1, 0);
        for (int s = 0; s < 3; s++) begin
            snooze = 1'b1;
            cyc();
            chk_all($sformatf("snz%0d enter", s), 0, 1, 0, 0, 1, 0);
            repeat (299) tick(1000);
            chk_all($sformatf("snz%0d 299", s), 0, 1, 0, 0, 1, 0);
            tick(1000);
            chk_all($sformatf("snz%0d wake", s), 1, 0, 0, 1, 1, 0);
        end
        snooze = 1'b1;
        cyc();
        chk_all("snz fourth", 0, 0, 0, 0, 1, 0);

        wr(3, 1, 10, 4, 2);
        tick(10);
        chk_all("ch3 trig", 8, 0, 3, 2, 9, 0);
        snooze = 1'b1;
        dismiss = 1'b1;
        cyc();
        chk_all("dis over snz", 0, 0, 0, 0, 9, 0);
        snooze = 1'b1;
        cyc();
        chk_all("snz idle", 0, 0, 0, 0, 9, 0);

        wr(1, 1, 30, 2, 1);
        wr_en = 1'b1;
        wr_idx = 2'd1;
        wr_arm = 1'b1;
        wr_time = 17'd30;
        wr_len = 8'd2;
        wr_music = 2'd1;
        sec_tick = 1'b1;
        cur_seconds = 17'd30;
        cyc();
        chk_all("write wins", 0, 0, 0, 0, 11, 0);
        tick(31);
        chk_all("write wins after", 0, 0, 0, 0, 11, 0);

        wr(2, 1, 20, 5, 3);
        tick(20);
        chk_all("ch2 trig", 4, 0, 2, 3, 15, 0);
        rst = 1'b1;
        sec_tick = 1'b1;
        cur_seconds = 17'd21;
        snooze = 1'b1;
        wr_en = 1'b1;
        wr_idx = 2'd0;
        wr_arm = 1'b1;
        wr_time = 17'd21;
        cyc();
        rst = 1'b0;
        chk_all("rst midring", 0, 0, 0, 0, 0, 0);
        tick(20);
        chk_all("rst no retrig", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
